// File: rtl/uart_rx_frame_pkg.sv
// Shared types and constants for the oversampled UART frame receiver.
package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Oversample ticks per bit and the three mid-bit vote points.
    localparam int unsigned OVS     = 16;
    localparam int unsigned VOTE_T0 = 6;
    localparam int unsigned VOTE_T1 = 7;
    localparam int unsigned VOTE_T2 = 8;

    // Tick-index width; wide enough for a 2-stop-bit window (32 ticks).
    localparam int unsigned TICK_W = 6;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial input plus received-word valid/ready bus of the UART receiver.
interface uart_rx_frame_if #(
    parameter int unsigned DBIT = 8
);
    logic            i_rx;
    logic [DBIT-1:0] o_data;
    logic            o_valid;
    logic            i_ready;
    logic            o_parity_err;
    logic            o_frame_err;
    logic            o_overrun;
    logic            o_busy;

    // Receiver side.
    modport master (
        input  i_rx,
        input  i_ready,
        output o_data,
        output o_valid,
        output o_parity_err,
        output o_frame_err,
        output o_overrun,
        output o_busy
    );

    // Line driver / word consumer side.
    modport slave (
        output i_rx,
        output i_ready,
        input  o_data,
        input  o_valid,
        input  o_parity_err,
        input  o_frame_err,
        input  o_overrun,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx_frame_baud_gen.sv
// Free-running mod-DIV counter producing the one-cycle oversample tick.
module uart_rx_frame_baud_gen #(
    parameter int unsigned DIV = 163
) (
    input  logic clk,
    input  logic rst,
    output logic tick_c
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick_c = (count == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver with majority voting, parity/stop checks
// and a valid/ready holding register with overrun detection.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DIV     = 163,
    parameter int unsigned PARITY  = PAR_NONE
) (
    input  logic            i_clock,
    input  logic            i_reset,
    uart_rx_frame_if.master bus
);
    localparam int unsigned BIT_W = 4;
    localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] T_STOP = TICK_W'(SB_TICK - 1);
    localparam logic [TICK_W-1:0] T_V0   = TICK_W'(VOTE_T0);
    localparam logic [TICK_W-1:0] T_V1   = TICK_W'(VOTE_T1);
    localparam logic [TICK_W-1:0] T_V2   = TICK_W'(VOTE_T2);
    localparam logic [BIT_W-1:0]  N_LAST = BIT_W'(DBIT - 1);

    logic              tick_c;
    logic              rx_meta;
    logic              rxs;
    logic              rxs_prev;
    state_t            state;
    logic [TICK_W-1:0] t;
    logic [BIT_W-1:0]  nbit;
    logic [2:0]        votes;
    logic [DBIT-1:0]   shreg;
    logic              par_err_q;
    logic              commit_pend;
    logic [DBIT-1:0]   data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              ovr_q;
    logic              busy_q;
    logic              vote_c;
    logic              par_exp_c;
    logic              handshake_c;

    uart_rx_frame_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk    (i_clock),
        .rst    (i_reset),
        .tick_c (tick_c)
    );

    assign vote_c      = majority3(votes);
    assign par_exp_c   = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
    assign handshake_c = valid_q & bus.i_ready;

    // Two-flop synchroniser plus one history flop for start-edge detection.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= bus.i_rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // Capture the three mid-bit samples of the current bit window.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            votes <= 3'b111;
        end else if (tick_c && state != ST_IDLE && state != ST_WAIT_IDLE) begin
            if (t == T_V0) votes[0] <= rxs;
            if (t == T_V1) votes[1] <= rxs;
            if (t == T_V2) votes[2] <= rxs;
        end
    end

    // Frame FSM, data shifter and output holding register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            t           <= '0;
            nbit        <= '0;
            shreg       <= '0;
            par_err_q   <= 1'b0;
            commit_pend <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Consumer handshake; a same-cycle commit below takes priority.
            if (handshake_c) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state  <= ST_START;
                        t      <= '0;
                        busy_q <= 1'b1;
                    end
                end

                ST_START: begin
                    if (tick_c) begin
                        if (t == T_LAST) begin
                            t <= '0;
                            if (vote_c) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state <= ST_DATA;
                                nbit  <= '0;
                            end
                        end else begin
                            t <= t + TICK_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (tick_c) begin
                        if (t == T_LAST) begin
                            t     <= '0;
                            shreg <= {vote_c, shreg[DBIT-1:1]};
                            if (nbit == N_LAST) begin
                                state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                nbit <= nbit + BIT_W'(1);
                            end
                        end else begin
                            t <= t + TICK_W'(1);
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick_c) begin
                        if (t == T_LAST) begin
                            t         <= '0;
                            par_err_q <= (vote_c != par_exp_c);
                            state     <= ST_STOP;
                        end else begin
                            t <= t + TICK_W'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (commit_pend) begin
                        commit_pend <= 1'b0;
                        data_q      <= shreg;
                        perr_q      <= (PARITY != PAR_NONE) ? par_err_q : 1'b0;
                        ferr_q      <= ~vote_c;
                        valid_q     <= 1'b1;
                        ovr_q       <= valid_q & ~bus.i_ready;
                        state       <= rxs ? ST_IDLE : ST_WAIT_IDLE;
                        busy_q      <= ~rxs;
                    end else if (tick_c) begin
                        if (t == T_STOP) begin
                            commit_pend <= 1'b1;
                        end else begin
                            t <= t + TICK_W'(1);
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (rxs) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = perr_q;
    assign bus.o_frame_err  = ferr_q;
    assign bus.o_overrun    = ovr_q;
    assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: one no-parity and one even-parity receiver.
module tb_uart_rx_frame;

    localparam int unsigned DIV = 5;
    localparam int unsigned BIT = DIV * 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } word_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_vec = 0;
    int    n_err = 0;
    word_t qn[$];
    word_t qe[$];

    always #5 clk = ~clk;

    uart_rx_frame_if #(.DBIT(8)) bn ();
    uart_rx_frame_if #(.DBIT(8)) be ();

    uart_rx_frame #(.DBIT(8), .SB_TICK(16), .DIV(DIV), .PARITY(0)) dut_n (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bn.master)
    );

    uart_rx_frame #(.DBIT(8), .SB_TICK(16), .DIV(DIV), .PARITY(1)) dut_e (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (be.master)
    );

    // Record every accepted word (valid & ready) on the falling edge.
    always @(negedge clk) begin
        if (bn.o_valid && bn.i_ready)
            qn.push_back({bn.o_data, bn.o_parity_err, bn.o_frame_err, bn.o_overrun});
        if (be.o_valid && be.i_ready)
            qe.push_back({be.o_data, be.o_parity_err, be.o_frame_err, be.o_overrun});
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) bn.i_rx = v;
        else            be.i_rx = v;
    endtask

    task automatic send_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(which, bits[i]);
            cyc(BIT);
        end
    endtask

    // Line-level frame: start 0, data LSB first, optional parity, stop.
    function automatic logic [15:0] build_frame(input logic [7:0] d, input int pmode,
                                                input logic bad_par, input logic stop,
                                                output int n);
        logic [15:0] b;
        b      = '0;
        b[8:1] = d;
        n      = 9;
        if (pmode != 0) begin
            b[9] = ((pmode == 1) ? ^d : ~^d) ^ bad_par;
            n    = 10;
        end
        b[n] = stop;
        n    = n + 1;
        return b;
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        bn.i_rx    = 1'b1;
        be.i_rx    = 1'b1;
        bn.i_ready = 1'b1;
        be.i_ready = 1'b1;
        cyc(3);
        n_vec++;
        if ({bn.o_valid, bn.o_data, bn.o_parity_err, bn.o_frame_err, bn.o_overrun, bn.o_busy} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_n: got %h expected 0",
                     {bn.o_valid, bn.o_data, bn.o_parity_err, bn.o_frame_err, bn.o_overrun, bn.o_busy});
        end
        n_vec++;
        if ({be.o_valid, be.o_data, be.o_parity_err, be.o_frame_err, be.o_overrun, be.o_busy} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_e: got %h expected 0",
                     {be.o_valid, be.o_data, be.o_parity_err, be.o_frame_err, be.o_overrun, be.o_busy});
        end
        rst = 1'b0;
        cyc(2 * BIT);
    endtask

    task automatic test_basic();
        logic [15:0] bits;
        int          n;
        word_t       w;
        bits = build_frame(8'h14, 0, 1'b0, 1'b1, n);
        send_bits(0, bits, n);
        set_line(0, 1'b1);
        cyc(BIT);
        n_vec++;
        if (qn.size() !== 1) begin
            n_err++;
            $display("FAIL basic_count: got %0d words expected 1", qn.size());
        end
        w = '1;
        if (qn.size() > 0) w = qn.pop_front();
        n_vec++;
        if (w !== {8'h14, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_word: got %h expected %h", w, {8'h14, 3'b000});
        end
        n_vec++;
        if (bn.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_valid_pulse: got %b expected 0", bn.o_valid);
        end
        qn.delete();
    endtask

    task automatic test_parity();
        logic [15:0] bits;
        int          n;
        word_t       w;
        for (int k = 0; k < 2; k++) begin
            bits = build_frame(8'h07, 1, k[0], 1'b1, n);
            send_bits(1, bits, n);
            set_line(1, 1'b1);
            cyc(BIT);
            w = '1;
            if (qe.size() > 0) w = qe.pop_front();
            n_vec++;
            if (w !== {8'h07, k[0], 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL parity_word_%0d: got %h expected %h", k, w, {8'h07, k[0], 2'b00});
            end
        end
        n_vec++;
        if (qe.size() !== 0) begin
            n_err++;
            $display("FAIL parity_extra: got %0d extra words expected 0", qe.size());
        end
        qe.delete();
    endtask

    task automatic test_break();
        logic [15:0] bits;
        int          n;
        word_t       w;
        bits = build_frame(8'h1E, 0, 1'b0, 1'b0, n);
        send_bits(0, bits, 9);
        set_line(0, 1'b0);
        cyc(10 * BIT);
        n_vec++;
        if (qn.size() !== 1 || bn.o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL break_hold: got words=%0d busy=%b expected words=1 busy=1", qn.size(), bn.o_busy);
        end
        cyc(10 * BIT);
        set_line(0, 1'b1);
        cyc(2 * BIT);
        n_vec++;
        if (qn.size() !== 1) begin
            n_err++;
            $display("FAIL break_count: got %0d words expected 1", qn.size());
        end
        w = '1;
        if (qn.size() > 0) w = qn.pop_front();
        n_vec++;
        if (w !== {8'h1E, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL break_word: got %h expected %h", w, {8'h1E, 3'b010});
        end
        n_vec++;
        if (bn.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL break_busy_end: got %b expected 0", bn.o_busy);
        end
        qn.delete();
    endtask

    task automatic test_glitch();
        set_line(0, 1'b0);
        cyc(5);
        n_vec++;
        if (bn.o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_rise: got %b expected 1", bn.o_busy);
        end
        cyc(3 * DIV - 5);
        set_line(0, 1'b1);
        cyc(18 * DIV + 10);
        n_vec++;
        if (bn.o_busy !== 1'b0 || bn.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_idle: got busy=%b valid=%b expected 0 0", bn.o_busy, bn.o_valid);
        end
        n_vec++;
        if (qn.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_words: got %0d expected 0", qn.size());
        end
        qn.delete();
    endtask

    task automatic test_overrun();
        logic [15:0] bits;
        int          n;
        word_t       w;
        bn.i_ready = 1'b0;
        bits = build_frame(8'h14, 0, 1'b0, 1'b1, n);
        send_bits(0, bits, n);
        set_line(0, 1'b1);
        cyc(BIT / 2);
        n_vec++;
        if ({bn.o_valid, bn.o_data, bn.o_overrun} !== {1'b1, 8'h14, 1'b0}) begin
            n_err++;
            $display("FAIL ovr_first: got %h expected %h", {bn.o_valid, bn.o_data, bn.o_overrun}, {1'b1, 8'h14, 1'b0});
        end
        bits = build_frame(8'h07, 0, 1'b0, 1'b1, n);
        send_bits(0, bits, n);
        set_line(0, 1'b1);
        cyc(BIT / 2);
        n_vec++;
        if ({bn.o_valid, bn.o_data, bn.o_overrun, bn.o_parity_err, bn.o_frame_err} !== {1'b1, 8'h07, 1'b1, 2'b00}) begin
            n_err++;
            $display("FAIL ovr_second: got %h expected %h",
                     {bn.o_valid, bn.o_data, bn.o_overrun, bn.o_parity_err, bn.o_frame_err}, {1'b1, 8'h07, 3'b100});
        end
        bn.i_ready = 1'b1;
        cyc(1);
        bn.i_ready = 1'b0;
        n_vec++;
        if ({bn.o_valid, bn.o_overrun} !== 2'b00) begin
            n_err++;
            $display("FAIL ovr_clear: got valid=%b overrun=%b expected 0 0", bn.o_valid, bn.o_overrun);
        end
        w = '1;
        if (qn.size() > 0) w = qn.pop_front();
        n_vec++;
        if (w !== {8'h07, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ovr_accepted: got %h expected %h", w, {8'h07, 3'b001});
        end
        bn.i_ready = 1'b1;
        cyc(BIT);
        qn.delete();
    endtask

    task automatic test_reset_mid();
        logic [15:0] bits;
        int          n;
        word_t       w;
        bits = build_frame(8'h14, 0, 1'b0, 1'b1, n);
        send_bits(0, bits, 5);
        n_vec++;
        if (bn.o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy_before: got %b expected 1", bn.o_busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bn.o_valid, bn.o_data, bn.o_parity_err, bn.o_frame_err, bn.o_overrun, bn.o_busy} !== 13'h0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got %h expected 0",
                     {bn.o_valid, bn.o_data, bn.o_parity_err, bn.o_frame_err, bn.o_overrun, bn.o_busy});
        end
        set_line(0, 1'b1);
        cyc(3);
        rst = 1'b0;
        cyc(2 * BIT);
        n_vec++;
        if (qn.size() !== 0) begin
            n_err++;
            $display("FAIL rstmid_partial: got %0d words expected 0", qn.size());
        end
        bits = build_frame(8'h1E, 0, 1'b0, 1'b1, n);
        send_bits(0, bits, n);
        set_line(0, 1'b1);
        cyc(BIT);
        w = '1;
        if (qn.size() > 0) w = qn.pop_front();
        n_vec++;
        if (w !== {8'h1E, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_word: got %h expected %h", w, {8'h1E, 3'b000});
        end
        qn.delete();
    endtask

    task automatic test_random();
        logic [15:0] bits;
        int          n;
        int          which;
        logic [7:0]  d;
        logic        bad;
        logic        stop;
        word_t       w;
        word_t       exp;
        for (int k = 0; k < 10; k++) begin
            which = k % 2;
            d     = 8'($urandom);
            bad   = (which == 1) ? 1'($urandom) : 1'b0;
            stop  = (($urandom % 4) != 0);
            exp   = {d, bad, ~stop, 1'b0};
            bits  = build_frame(d, which, bad, stop, n);
            send_bits(which, bits, n);
            set_line(which, 1'b1);
            cyc($urandom_range(2 * BIT, BIT / 2));
            w = '1;
            if (which == 0) begin
                if (qn.size() > 0) w = qn.pop_front();
            end else begin
                if (qe.size() > 0) w = qe.pop_front();
            end
            n_vec++;
            if (w !== exp) begin
                n_err++;
                $display("FAIL random_%0d_dut%0d: got %h expected %h", k, which, w, exp);
            end
        end
        n_vec++;
        if (qn.size() + qe.size() !== 0) begin
            n_err++;
            $display("FAIL random_extra: got %0d extra words expected 0", qn.size() + qe.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
